// File: rtl/frame_pkg.sv
// Shared constants, state encoding and byte-lane helper for the frame memory write path.
package frame_pkg;

  localparam int FRAME_WORDS  = 76800;
  localparam int FRAME_ADDR_W = 17;
  localparam int MEM_DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    WRITE = 2'd2,
    DROP  = 2'd3
  } fb_state_e;

  // Lowest ceil(pixel_w/8) byte lanes of the 32-bit memory word.
  function automatic logic [3:0] be_for_width(input int pixel_w);
    logic [3:0] be;
    int lanes;
    lanes = (pixel_w + 7) / 8;
    be = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < lanes) be[i] = 1'b1;
    end
    return be;
  endfunction

endpackage

// File: rtl/frame_buffer_writer.sv
// Pixel stream to frame memory writer: framing FSM, pixel counter and registered memory port.
//
// state | meaning
// IDLE  | capture disabled, all beats discarded
// SYNC  | waiting for a start-of-frame beat
// WRITE | writing pixels 1..NUM_WORDS-1 of the current frame
// DROP  | frame overran NUM_WORDS, discarding until end-of-frame
module frame_buffer_writer
  import frame_pkg::*;
#(
  parameter int NUM_WORDS = FRAME_WORDS,
  parameter int ADDR_W    = FRAME_ADDR_W,
  parameter int PIXEL_W   = 24,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PIXEL_W-1:0]    st_data,
  input  logic                  st_valid,
  input  logic                  st_sop,
  input  logic                  st_eop,
  output logic                  st_ready,
  input  logic                  enable,
  input  logic                  clear_err,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  busy,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [3:0]            mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [MEM_DATA_W-1:0] mem_writedata,
  output logic                  mem_clken
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_SYNC  = 2'(SYNC);
  localparam logic [1:0] ST_WRITE = 2'(WRITE);
  localparam logic [1:0] ST_DROP  = 2'(DROP);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [3:0]        BE   = be_for_width(PIXEL_W);

  logic              live;
  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] wr_idx;
  logic              wr_nxt;
  logic              done_nxt;
  logic              set_short;
  logic              set_long;
  logic              start;
  logic              accept;

  assign st_ready       = live;
  assign mem_clken      = live;
  assign mem_byteenable = live ? BE : 4'b0000;
  assign accept         = st_valid & live;
  assign busy           = (state == ST_WRITE) || (state == ST_DROP);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_nxt    = 1'b0;
    wr_idx    = '0;
    done_nxt  = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    start     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        if (!enable) state_nxt = ST_IDLE;
        else if (accept && st_sop) start = 1'b1;
      end
      ST_WRITE: begin
        if (accept) begin
          if (st_sop) begin
            set_short = 1'b1;
            start     = 1'b1;
          end else begin
            wr_nxt = 1'b1;
            wr_idx = cnt;
            if (cnt == LAST) begin
              cnt_nxt = '0;
              if (st_eop) begin
                done_nxt  = 1'b1;
                state_nxt = enable ? ST_SYNC : ST_IDLE;
              end else begin
                set_long  = 1'b1;
                state_nxt = ST_DROP;
              end
            end else if (st_eop) begin
              set_short = 1'b1;
              cnt_nxt   = '0;
              state_nxt = ST_SYNC;
            end else begin
              cnt_nxt = cnt + ADDR_W'(1);
            end
          end
        end
      end
      ST_DROP: begin
        if (accept) begin
          if (st_sop) begin
            if (enable) start = 1'b1;
            else        state_nxt = ST_IDLE;
          end else if (st_eop) begin
            state_nxt = enable ? ST_SYNC : ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A start-of-frame beat always lands at pixel 0, whichever state saw it.
    if (start) begin
      wr_nxt = 1'b1;
      wr_idx = '0;
      if (LAST == '0) begin
        cnt_nxt = '0;
        if (st_eop) begin
          done_nxt  = 1'b1;
          state_nxt = enable ? ST_SYNC : ST_IDLE;
        end else begin
          set_long  = 1'b1;
          state_nxt = ST_DROP;
        end
      end else if (st_eop) begin
        set_short = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ST_SYNC;
      end else begin
        cnt_nxt   = ADDR_W'(1);
        state_nxt = ST_WRITE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live  <= 1'b0;
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      live  <= 1'b1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_write      <= 1'b0;
      mem_chipselect <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      frame_done     <= 1'b0;
    end else begin
      mem_write      <= wr_nxt;
      mem_chipselect <= wr_nxt;
      frame_done     <= done_nxt;
      if (wr_nxt) begin
        mem_address   <= BASE + wr_idx;
        mem_writedata <= MEM_DATA_W'(st_data);
      end
    end
  end

  // Error set takes priority over a coincident clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      if (done_nxt) frame_count <= frame_count + 16'd1;
      if (set_short)      err_short <= 1'b1;
      else if (clear_err) err_short <= 1'b0;
      if (set_long)       err_long <= 1'b1;
      else if (clear_err) err_long <= 1'b0;
    end
  end

endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
- Streaming-to-memory stage directly upstream of the 76800-word on-chip frame memory (32-bit words, 17-bit word address, single-port, byte-enabled, no waitrequest).
- Accepts a pixel stream with start/end-of-frame markers from the camera/preprocessing path.
- Writes one pixel per memory word, addresses 0..NUM_WORDS-1 (320x240 frame).
- Enforces frame framing and reports frame completion and framing errors to the Nios control path.

Parameters:
- NUM_WORDS, 76800, pixels per frame = memory depth in words.
- ADDR_W, 17, memory word-address width.
- PIXEL_W, 24, pixel width, 1..32; zero-extended into the 32-bit word.
- BASE_ADDR, 0, word address of pixel 0; BASE_ADDR+NUM_WORDS must be <= 2^ADDR_W.

Ports:
- clk  in  1  single clock for the block and the memory port.
- reset_n  in  1  asynchronous, active-low reset.
- st_data  in  PIXEL_W  pixel data.
- st_valid  in  1  beat valid.
- st_sop  in  1  first pixel of frame, qualified by st_valid.
- st_eop  in  1  last pixel of frame, qualified by st_valid.
- st_ready  out  1  beat accepted when st_valid & st_ready.
- enable  in  1  capture enable, level.
- clear_err  in  1  single-cycle pulse; clears sticky error flags.
- frame_done  out  1  single-cycle pulse after the last write of a good frame.
- frame_count  out  16  good frames written, wraps 0xFFFF->0.
- err_short  out  1  sticky: frame ended before NUM_WORDS pixels.
- err_long  out  1  sticky: NUM_WORDS pixels received without eop.
- busy  out  1  high in WRITE or DROP.
- mem_address  out  ADDR_W  word address.
- mem_byteenable  out  4  byte lanes covering PIXEL_W, constant.
- mem_chipselect  out  1  asserted with mem_write.
- mem_write  out  1  write strobe.
- mem_writedata  out  32  zero-extended pixel.
- mem_clken  out  1  constant 1 after reset.

Behaviour:
- Reset state: all outputs 0 and state IDLE. st_ready=0 and mem_clken=0 while reset_n is low.
- After reset: st_ready=1 every cycle. The memory never stalls, so the block never backpressures. Beats not written are discarded.
- Memory outputs are registered. An accepted beat produces mem_write=mem_chipselect=1 in the next cycle with its address and data, for exactly one cycle. Latency is 1 cycle. mem_byteenable = lowest ceil(PIXEL_W/8) bits set; 4'b0111 for 24.
- pix_cnt: ADDR_W-bit counter. mem_address = BASE_ADDR + pix_cnt.

State machine:
- IDLE:
  - Discard all beats.
  - Go to SYNC when enable=1.
- SYNC:
  - Discard beats until a beat with st_sop=1.
  - That beat is written at pix_cnt=0, then go to WRITE with pix_cnt=1.
  - If that beat also has st_eop=1 and NUM_WORDS>1, it is a short frame: set err_short, stay SYNC.
  - If enable=0 while in SYNC, go to IDLE.
- WRITE:
  - Each beat is written at pix_cnt, then pix_cnt increments.
  - If st_eop=1 and pix_cnt==NUM_WORDS-1: good frame. Pulse frame_done on the cycle the last mem_write is driven. Increment frame_count. Go to SYNC if enable=1, else IDLE.
  - If st_eop=1 and pix_cnt<NUM_WORDS-1: the pixel is written, set err_short, go to SYNC. No frame_done.
  - If st_sop=1 (mid-frame): set err_short. The beat is written at pix_cnt=0 as the new frame's first pixel, pix_cnt:=1, stay WRITE. A beat with sop and eop together follows SYNC rules.
  - If pix_cnt==NUM_WORDS-1 and st_eop=0: the beat is written, set err_long, go to DROP.
- DROP:
  - Discard beats until st_eop=1, then go to SYNC (or IDLE if enable=0).
  - A st_sop beat in DROP is treated as in SYNC.
- Enable deassertion in WRITE is ignored until the frame ends (good, short, or long). No partial abort.
- Errors:
  - err_short and err_long are sticky; clear_err clears them.
  - If clear_err and a new error event fall in the same cycle, the set wins.
- Counter limits: pix_cnt never exceeds NUM_WORDS-1, so no write ever targets an address >= BASE_ADDR+NUM_WORDS.
- Reset mid-frame: immediate return to IDLE. Any in-flight write is dropped (mem_write=0). frame_count and the error flags are cleared.

Decomposition:
- Shared package frame_pkg:
  - FRAME_WORDS=76800, FRAME_ADDR_W=17, MEM_DATA_W=32.
  - State enum {IDLE, SYNC, WRITE, DROP}.
  - Function be_for_width(PIXEL_W) returning the byteenable constant.
- No sub-module needed: a single FSM with counter and output register. The memory output register stage may be a small inline always block.

Test Plan:
- NUM_WORDS=16, enable=1, 16 beats data=0..15, sop on beat 0, eop on beat 15, no gaps -> 16 writes at addresses 0..15 with writedata=beat value, byteenable=4'b0111; frame_done pulses once coincident with address 15; frame_count=1; no errors.
- Beats before first sop (5 junk beats, then a good 16-beat frame) -> no writes for the junk; frame written at 0..15.
- eop on beat 9 -> writes at 0..9, err_short=1, no frame_done; following good frame -> frame_count=1; clear_err pulse -> err_short=0.
- 20 beats without eop, then eop on beat 20 -> writes at 0..15 only, err_long=1, beats 16..20 discarded, state returns to SYNC.
- enable dropped at beat 4 of a frame -> frame completes (16 writes, frame_done); next sop frame is not written while enable=0.
- reset_n low at beat 7 -> mem_write=0 at once, all status cleared; after release a full frame is written starting at address 0.
